// File: rtl/synth_audio_pkg.sv
// synth_audio_pkg: shared mixer types and the sample clip helper.
package synth_audio_pkg;
  localparam int SAMPLE_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} mix_state_t;
  function automatic logic signed [31:0] sat_to_sample(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/sample_saturate.sv
// sample_saturate: clips a wide signed accumulator to a SAMPLE_W signed sample.
module sample_saturate
  import synth_audio_pkg::*;
#(
  parameter int ACC_W = 18,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [SAMPLE_W-1:0] sample
);
  assign sample = SAMPLE_W'(sat_to_sample(32'(acc), SAMPLE_W));
endmodule

// File: rtl/voice_mix_scheduler.sv
// voice_mix_scheduler: polls enabled voices over req/ack once per I2S frame and presents the saturated stereo mix.
// Optional VOICE_MIX_ATTEN_EN adds master_shift, an arithmetic right shift of the sums before clipping.
module voice_mix_scheduler
  import synth_audio_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_clk,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  output logic [NUM_VOICES-1:0]          voice_req,
  input  logic [NUM_VOICES-1:0]          voice_ack,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_left,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_right,
  input  logic                           err_clear,
`ifdef VOICE_MIX_ATTEN_EN
  input  logic [2:0]                     master_shift,
`endif
  output logic [SAMPLE_W-1:0]            sample_left,
  output logic [SAMPLE_W-1:0]            sample_right,
  output logic                           sample_valid,
  output logic                           busy,
  output logic                           overrun,
  output logic                           timeout_err
);
  localparam int AW = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int IW = $clog2(NUM_VOICES + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  mix_state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] wcnt;
  logic signed [AW-1:0] acc_l, acc_r, sh_l, sh_r;
  logic signed [SAMPLE_W-1:0] pend_l, pend_r, sat_l, sat_r, l_sel, r_sel;
  logic [NUM_VOICES-1:0] sel;
  logic prev_fclk, frame_edge, idx_done, ack_hit, en_hit, tmo;
  assign frame_edge = prev_fclk & ~frame_clk;
  assign sel = NUM_VOICES'(1) << idx;
  assign idx_done = idx == IW'(NUM_VOICES);
  assign ack_hit = |(voice_ack & sel);
  assign en_hit = |(voice_enable & sel);
  assign tmo = wcnt == CW'(TIMEOUT);
  assign busy = state != IDLE;
  always_comb begin
    l_sel = '0;
    r_sel = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      l_sel = sel[i] ? voice_left[i*SAMPLE_W +: SAMPLE_W] : l_sel;
      r_sel = sel[i] ? voice_right[i*SAMPLE_W +: SAMPLE_W] : r_sel;
    end
  end
`ifdef VOICE_MIX_ATTEN_EN
  assign sh_l = acc_l >>> master_shift;
  assign sh_r = acc_r >>> master_shift;
`else
  assign sh_l = acc_l;
  assign sh_r = acc_r;
`endif
  sample_saturate #(.ACC_W(AW), .SAMPLE_W(SAMPLE_W)) u_sat_l (.acc(sh_l), .sample(sat_l));
  sample_saturate #(.ACC_W(AW), .SAMPLE_W(SAMPLE_W)) u_sat_r (.acc(sh_r), .sample(sat_r));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      wcnt <= '0;
      acc_l <= '0;
      acc_r <= '0;
      pend_l <= '0;
      pend_r <= '0;
      prev_fclk <= 1'b0;
      voice_req <= '0;
      sample_left <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      prev_fclk <= frame_clk;
      sample_valid <= frame_edge;
      if (err_clear) begin
        overrun <= 1'b0;
        timeout_err <= 1'b0;
      end
      // a mix finishing on the edge itself is forwarded rather than reported stale
      if (frame_edge) begin
        sample_left <= state == DONE ? sat_l : pend_l;
        sample_right <= state == DONE ? sat_r : pend_r;
      end
      if (frame_edge && state != DONE) begin
        overrun <= state == IDLE ? overrun & ~err_clear : 1'b1;
        voice_req <= '0;
        acc_l <= '0;
        acc_r <= '0;
        idx <= '0;
        state <= SCAN;
      end else begin
        case (state)
          SCAN: begin
            if (idx_done) state <= DONE;
            else if (en_hit) begin
              voice_req <= sel;
              wcnt <= '0;
              state <= WAIT;
            end else idx <= idx + IW'(1);
          end
          WAIT: begin
            if (ack_hit || tmo) begin
              acc_l <= ack_hit ? acc_l + AW'(l_sel) : acc_l;
              acc_r <= ack_hit ? acc_r + AW'(r_sel) : acc_r;
              timeout_err <= ack_hit ? timeout_err & ~err_clear : 1'b1;
              voice_req <= '0;
              idx <= idx + IW'(1);
              state <= SCAN;
            end else wcnt <= wcnt + CW'(1);
          end
          DONE: begin
            pend_l <= sat_l;
            pend_r <= sat_r;
            acc_l <= '0;
            acc_r <= '0;
            idx <= '0;
            state <= frame_edge ? SCAN : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_voice_mix_scheduler.sv
// tb_voice_mix_scheduler: directed frames with a queued scoreboard checked on every sample_valid.
module tb_voice_mix_scheduler;
  logic clk, reset, frame_clk, err_clear;
  logic [3:0] voice_enable, voice_req, voice_ack;
  logic [63:0] voice_left, voice_right;
  logic [15:0] sample_left, sample_right;
  logic sample_valid, busy, overrun, timeout_err;
  logic signed [15:0] vl [4];
  logic signed [15:0] vr [4];
  int dly [4];
  int cnt [4];
  int last_len [4];
  int reqcnt [4];
  int onehot_err;
  int passed, total;
  int exp_l [$];
  int exp_r [$];
  int snap1, snap3;

  assign voice_left = {vl[3], vl[2], vl[1], vl[0]};
  assign voice_right = {vr[3], vr[2], vr[1], vr[0]};

  voice_mix_scheduler #(.NUM_VOICES(4), .SAMPLE_W(16), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .frame_clk(frame_clk),
    .voice_enable(voice_enable),
    .voice_req(voice_req),
    .voice_ack(voice_ack),
    .voice_left(voice_left),
    .voice_right(voice_right),
    .err_clear(err_clear),
`ifdef VOICE_MIX_ATTEN_EN
    .master_shift(3'd0),
`endif
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .busy(busy),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    voice_ack = '0;
    onehot_err = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      last_len[i] = 0;
      reqcnt[i] = 0;
    end
  end

  // voice model: acks on the dly-th cycle of a request, never when dly is 0
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (voice_req[i]) begin
        if (cnt[i] == 0) reqcnt[i]++;
        cnt[i]++;
        voice_ack[i] = dly[i] != 0 && cnt[i] == dly[i];
      end else begin
        if (cnt[i] != 0) last_len[i] = cnt[i];
        cnt[i] = 0;
        voice_ack[i] = 1'b0;
      end
    end
    if ($countones(voice_req) > 1) onehot_err++;
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      total++;
      if (exp_l.size() == 0) begin
        $display("FAIL unexpected_valid: got L=%0d R=%0d, required no output", $signed(sample_left), $signed(sample_right));
      end else begin
        int el, er;
        el = exp_l.pop_front();
        er = exp_r.pop_front();
        if (int'($signed(sample_left)) == el && int'($signed(sample_right)) == er) passed++;
        else $display("FAIL mix_output: got L=%0d R=%0d, required L=%0d R=%0d", $signed(sample_left), $signed(sample_right), el, er);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  task automatic fe(input int el, input int er);
    exp_l.push_back(el);
    exp_r.push_back(er);
    @(negedge clk) frame_clk = 1'b1;
    @(negedge clk) frame_clk = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_voices(input int l, input int r, input int d);
    for (int i = 0; i < 4; i++) begin
      vl[i] = 16'(l);
      vr[i] = 16'(r);
      dly[i] = d;
    end
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    frame_clk = 1'b0;
    err_clear = 1'b0;
    voice_enable = 4'hF;
    set_voices(17, -5, 2);
    idle(3);
    check("rst_left", int'(sample_left), 0);
    check("rst_req", int'(voice_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_flags", int'({overrun, timeout_err, sample_valid}), 0);
    reset = 1'b0;
    idle(2);
    // four voices of 17/-5; first edge shows the empty pending buffer
    fe(0, 0);
    idle(40);
    check("idle_after_mix", int'(busy), 0);
    fe(68, -20);
    idle(40);
    check("no_flags", int'({overrun, timeout_err}), 0);
    // saturation with two voices
    voice_enable = 4'b0011;
    vl[0] = 32000; vl[1] = 32000; vr[0] = -32000; vr[1] = -32000;
    fe(68, -20);
    idle(40);
    fe(32767, -32768);
    idle(40);
    // sparse enable: voices 1 and 3 must never be requested
    voice_enable = 4'b0101;
    vl[0] = 10; vl[1] = 1000; vl[2] = 20; vl[3] = 3000;
    vr[0] = 1;  vr[1] = 100;  vr[2] = 2;  vr[3] = 300;
    snap1 = reqcnt[1];
    snap3 = reqcnt[3];
    fe(32767, -32768);
    idle(40);
    check("req_v1_skipped", reqcnt[1] - snap1, 0);
    check("req_v3_skipped", reqcnt[3] - snap3, 0);
    fe(30, 3);
    idle(40);
    // voice 2 silent: 9-cycle request then timeout
    voice_enable = 4'hF;
    set_voices(17, -5, 2);
    dly[2] = 0;
    fe(30, 3);
    idle(60);
    check("req2_len", last_len[2], 9);
    check("timeout_set", int'(timeout_err), 1);
    check("no_overrun", int'(overrun), 0);
    dly[2] = 2;
    fe(51, -15);
    idle(40);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    check("timeout_cleared", int'(timeout_err), 0);
    // frame edge mid-WAIT: stale pending shown, mix restarts at voice 0
    set_voices(17, -5, 0);
    fe(68, -20);
    idle(2);
    fe(68, -20);
    idle(1);
    check("overrun_set", int'(overrun), 1);
    check("req_dropped", int'(voice_req), 0);
    check("busy_restart", int'(busy), 1);
    idle(1);
    check("restart_idx0", int'(voice_req), 1);
    idle(80);
    // async reset mid-WAIT
    fe(0, 0);
    idle(3);
    check("req_before_rst", int'(voice_req), 1);
    #1 reset = 1'b1;
    #1;
    check("async_req", int'(voice_req), 0);
    check("async_busy", int'(busy), 0);
    check("async_out", int'({sample_left, sample_right}), 0);
    check("async_flags", int'({overrun, timeout_err, sample_valid}), 0);
    idle(2);
    check("onehot_req", onehot_err, 0);
    check("queue_drained", exp_l.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/voice_mix_scheduler.md
Name: voice_mix_scheduler

Overview:
- Sequences per-frame sample collection from NUM_VOICES voice generators over a req/ack handshake.
- Sums the left and right voice samples with saturation.
- Presents a stable stereo pair on sample_left/sample_right for i2s_controller, updated once per I2S frame.
- Sits between the voice bank and i2s_controller and runs on the same clk.

Parameters:
- NUM_VOICES, 4, number of requesters (voices); must be 2 or more.
- SAMPLE_W, 16, signed sample width.
- TIMEOUT, 255, max cycles to wait for a voice ack before substituting 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  frame clock from i2s_controller, synchronous to clk; a falling edge starts a new stereo frame.
- voice_enable  in  NUM_VOICES  per-voice enable; disabled voices are skipped.
- voice_req  out  NUM_VOICES  one-hot request to voice idx.
- voice_ack  in  NUM_VOICES  voice idx has valid sample this cycle.
- voice_left  in  NUM_VOICES*SAMPLE_W  packed signed left samples; voice i at [i*SAMPLE_W +: SAMPLE_W].
- voice_right  in  NUM_VOICES*SAMPLE_W  packed signed right samples, same packing.
- err_clear  in  1  clears the sticky error flags.
- sample_left  out  SAMPLE_W  mixed left sample to i2s_controller.
- sample_right  out  SAMPLE_W  mixed right sample to i2s_controller.
- sample_valid  out  1  one-cycle pulse when sample_left/right update.
- busy  out  1  mix in progress (state is not IDLE).
- overrun  out  1  sticky: a frame edge arrived before the mix completed.
- timeout_err  out  1  sticky: a voice failed to ack within TIMEOUT.

Behaviour:
- Reset values: all outputs 0; pending buffer 0; accumulators 0; idx 0; wait counter 0; frame_clk history register 0; state IDLE.
- Reset mid-operation drops voice_req immediately and abandons the mix.
- Frame edge: frame_edge = prev_fclk & ~frame_clk, using a registered prev_fclk.
- On frame_edge, the output registers load from the pending buffer and sample_valid pulses the next cycle.
- Output latency: a mix started at frame N appears on the outputs at frame N+1.
- State IDLE: on frame_edge, clear accL/accR, idx←0, go to SCAN.
- State SCAN (1 cycle per voice):
  - If voice_enable[idx]=0: idx←idx+1.
  - Else: assert voice_req[idx], clear the wait counter, go to WAIT.
  - When idx has passed NUM_VOICES-1, go to DONE.
- State WAIT: voice_req[idx] holds high.
  - On voice_ack[idx]: accL += sext(voice_left[idx]), accR += sext(voice_right[idx]); drop req; idx←idx+1; go to SCAN.
  - Else, when the counter reaches TIMEOUT: contribute 0, set timeout_err, drop req, idx+1, go to SCAN.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from non-requested voices are ignored.
- State DONE (1 cycle): pending ← saturate(acc) to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]; go to IDLE.
- Widths: accumulators are SAMPLE_W+$clog2(NUM_VOICES) bits signed; the wait counter is $clog2(TIMEOUT+1) bits.
- frame_edge in WAIT or SCAN (overrun):
  - Set overrun; outputs load the stale pending buffer; drop req.
  - Restart the mix: acc cleared, idx←0, go to SCAN.
- frame_edge in the same cycle as DONE: the DONE write is forwarded, so the outputs get the fresh mix and no overrun is flagged.
- All voices disabled: SCAN walks the indices and DONE writes 0.
- err_clear clears both sticky flags. Err_clear together with a new error event in the same cycle leaves the flag set.
- At most one voice_req bit is high in any cycle.

Optional Feature:
- Macro VOICE_MIX_ATTEN_EN.
- Defined: adds input master_shift [2:0]. accL and accR are arithmetic-shifted right by master_shift before saturation in DONE.
- Undefined: port absent; no shift.

Decomposition:
- Package synth_audio_pkg: SAMPLE_W default constant, mix_state_t enum (IDLE, SCAN, WAIT, DONE), function sat_to_sample.
- One sub-module: sample_saturate (parameterised acc width to SAMPLE_W clip), instantiated twice, for L and R.

Test Plan:
- NUM_VOICES=4, all enabled, each voice acks after 2 cycles with L=17, R=-5:
  - after the second frame edge, sample_left=68, sample_right=-20, sample_valid pulses once, no flags set.
- Saturation: two voices with L=32000 and R=-32000:
  - sample_left=32767, sample_right=-32768.
- voice_enable=4'b0101:
  - voice_req is never asserted for voices 1 and 3; sum covers voices 0 and 2 only.
- Voice 2 never acks, TIMEOUT=8:
  - req[2] high exactly 9 cycles (counter 0 through 8), then drops; timeout_err=1; sum excludes voice 2.
  - err_clear → timeout_err=0.
- Frame edge while in WAIT:
  - overrun=1; outputs show the previous mix; mix restarts at idx 0.
- Async reset asserted mid-WAIT:
  - voice_req=0 with no clock edge; all outputs 0; state IDLE.
